// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the sequential radix-4 Booth multiplier.
//   XLEN_DEFAULT : default operand width
//   mul_op_e     : op encoding (MUL low half, MULH s*s, MULHSU s*u, MULHU u*u)
//   mul_state_e  : control FSM states
// -----------------------------------------------------------------------------
package mul_pkg;

   localparam int XLEN_DEFAULT = 64;

   typedef enum logic [1:0] {
      MUL    = 2'b00,
      MULH   = 2'b01,
      MULHSU = 2'b10,
      MULHU  = 2'b11
   } mul_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } mul_state_e;

endpackage

// File: rtl/booth_sel.sv
// -----------------------------------------------------------------------------
// booth_sel
// Radix-4 Booth digit selector. Maps a 3-bit multiplier window
// {y[2i+1], y[2i], y[2i-1]} to a partial product of 0, +-X or +-2X.
//   bits  : multiplier window
//   mcand : multiplicand X, already sign/zero extended to XW bits
//   pp    : selected partial product, XW+1 bits (room for 2X)
// -----------------------------------------------------------------------------
module booth_sel #(
   parameter int XW = 66
) (
   input  logic [2:0]    bits,
   input  logic [XW-1:0] mcand,
   output logic [XW:0]   pp
);

   logic [XW:0] x1;
   logic [XW:0] x2;

   assign x1 = {mcand[XW-1], mcand};
   assign x2 = {mcand, 1'b0};

   // The multiplicand comes from an XLEN-bit operand, so |X| is far below
   // 2^(XW-1) and negating 2X cannot overflow XW+1 bits.
   always_comb begin
      pp = '0;
      case (bits)
         3'b001, 3'b010: pp = x1;
         3'b011:         pp = x2;
         3'b100:         pp = -x2;
         3'b101, 3'b110: pp = -x1;
         default:        pp = '0;
      endcase
   end

endmodule

// File: rtl/mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq
// Sequential multiplier, one radix-4 Booth step (2 multiplier bits) per cycle.
// Operands are extended to XLEN+2 bits so that signed, unsigned and mixed
// products all come out of a single signed Booth recoding.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : request handshake (ready only in IDLE)
//   op, word             : operation select, 32-bit word mode (when W_EN != 0)
//   operand1, operand2   : multiplicand, multiplier
//   flush                : abort any in-flight operation
//   out_valid / out_ready: result handshake (valid only in DONE)
//   result_h, result_l   : full 2*XLEN-bit product halves
//   result               : op-selected architectural result
// All result outputs read zero while out_valid is low.
// -----------------------------------------------------------------------------
module mul_seq
   import mul_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int W_EN = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic            word,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result_h,
   output logic [XLEN-1:0] result_l,
   output logic [XLEN-1:0] result
);

   localparam int XW    = XLEN + 2;       // extended operand width
   localparam int AW    = 2 * XLEN + 4;   // accumulator width
   localparam int NSTEP = XW / 2;         // Booth steps per operation
   localparam int CW    = $clog2(NSTEP + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);

   mul_state_e      state_reg;
   mul_state_e      state_next;
   logic [CW-1:0]   cnt_reg;
   logic [AW-1:0]   acc_reg;
   logic [XW-1:0]   mcand_reg;
   logic [XW:0]     mplr_reg;   // multiplier with an implicit y[-1]=0 at bit 0
   mul_op_e         op_reg;
   logic            word_reg;

   logic            accept;
   mul_op_e         op_in;
   logic            word_in;
   logic            sign1;
   logic            sign2;
   logic [XW-1:0]   ext1;
   logic [XW-1:0]   ext2;
   logic [XW:0]     pp;
   logic [AW-1:0]   pp_ext;
   logic [AW-1:0]   pp_shifted;
   logic            unused_acc_top;

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign accept    = (state_reg == IDLE) && in_valid && !flush;

   // Operand extension at accept time. Each operand's sign comes from its own
   // MSB; word mode treats both low words as signed and forces MUL.
   always_comb begin
      op_in   = mul_op_e'(op);
      word_in = (W_EN != 0) && word;
      sign1   = 1'b0;
      sign2   = 1'b0;
      if (word_in) begin
         op_in = MUL;
         ext1  = XW'(signed'(operand1[31:0]));
         ext2  = XW'(signed'(operand2[31:0]));
      end else begin
         sign1 = operand1[XLEN-1] && ((op_in == MULH) || (op_in == MULHSU));
         sign2 = operand2[XLEN-1] && (op_in == MULH);
         ext1  = {{2{sign1}}, operand1};
         ext2  = {{2{sign2}}, operand2};
      end
   end

   booth_sel #(
      .XW(XW)
   ) u_booth_sel (
      .bits  (mplr_reg[2:0]),
      .mcand (mcand_reg),
      .pp    (pp)
   );

   // Partial product for step i carries weight 4^i.
   assign pp_ext     = AW'(signed'(pp));
   assign pp_shifted = pp_ext << {cnt_reg, 1'b0};

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next-state logic; flush wins over every other input
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid) state_next = CALC;
         CALC:    if (cnt_reg == LAST_STEP) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush) begin
         state_next = IDLE;
      end
   end

   // Datapath: operand capture and Booth accumulation
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg   <= '0;
         acc_reg   <= '0;
         mcand_reg <= '0;
         mplr_reg  <= '0;
         op_reg    <= MUL;
         word_reg  <= 1'b0;
      end else if (accept) begin
         cnt_reg   <= '0;
         acc_reg   <= '0;
         mcand_reg <= ext1;
         mplr_reg  <= {ext2, 1'b0};
         op_reg    <= op_in;
         word_reg  <= word_in;
      end else if ((state_reg == CALC) && !flush) begin
         acc_reg  <= acc_reg + pp_shifted;
         // arithmetic shift exposes the next 3-bit window at bits [2:0]
         mplr_reg <= {{2{mplr_reg[XW]}}, mplr_reg[XW:2]};
         cnt_reg  <= cnt_reg + 1'b1;
      end
   end

   // Bits above 2*XLEN only hold sign extension of the exact product.
   assign unused_acc_top = ^acc_reg[AW-1:2*XLEN];

   // Result outputs, gated to zero outside DONE
   always_comb begin
      result_l = '0;
      result_h = '0;
      result   = '0;
      if (state_reg == DONE) begin
         result_l = acc_reg[XLEN-1:0];
         result_h = acc_reg[2*XLEN-1:XLEN];
         if (word_reg) begin
            result = XLEN'(signed'(acc_reg[31:0]));
         end else if (op_reg == MUL) begin
            result = acc_reg[XLEN-1:0];
         end else begin
            result = acc_reg[2*XLEN-1:XLEN];
         end
      end
   end

endmodule
